// File: rtl/counter_updown_mod.sv
`default_nettype none
// ============================================================================
// Module      : counter_updown_mod
// Description : Modulo-N up/down counter with count enable, runtime direction,
//               synchronous clamped parallel load, registered wrap pulse and
//               sticky overflow flag. Synchronous active-low reset.
//               Optional build macro COUNTER_UPDOWN_SATURATE_EN: saturate at
//               the terminal value instead of wrapping; wrap/ovf_sticky then
//               report blocked steps.
//               Parameter legality: WIDTH >= 1, 2 <= MODULUS <= 2**WIDTH,
//               RESET_VAL < MODULUS.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_updown_mod #(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 2 ** WIDTH,
    parameter int RESET_VAL = 0
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             wrap,
    output logic             ovf_sticky
);

    // Highest legal count; MODULUS-1 always fits in WIDTH bits.
    localparam logic [WIDTH-1:0] c_MAX       = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] c_ZERO      = '0;
    localparam logic [WIDTH-1:0] c_ONE       = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_RESET_VAL = WIDTH'(RESET_VAL);

    // Value taken when a step is attempted from the terminal count.
`ifdef COUNTER_UPDOWN_SATURATE_EN
    localparam logic [WIDTH-1:0] c_UP_TERM = c_MAX;   // stick at top
    localparam logic [WIDTH-1:0] c_DN_TERM = c_ZERO;  // stick at bottom
`else
    localparam logic [WIDTH-1:0] c_UP_TERM = c_ZERO;  // roll over to 0
    localparam logic [WIDTH-1:0] c_DN_TERM = c_MAX;   // roll under to top
`endif

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             ovf_q;
    logic             ovf_d;

    logic             w_at_max;
    logic             w_at_zero;
    logic             w_tc;
    logic             w_wrap_evt;
    logic             w_load_ok;
    logic [WIDTH-1:0] w_load_clamped;

    assign w_at_max  = (q_q == c_MAX);
    assign w_at_zero = (q_q == c_ZERO);

    // Terminal count: the step at the coming edge (if taken) hits the boundary.
    assign w_tc = en & ((up_dn & w_at_max) | (~up_dn & w_at_zero));

    // Load takes priority over counting, so a load edge never reports a wrap.
    // In saturate builds the same condition marks a blocked step.
    assign w_wrap_evt = w_tc & ~load;

    // load_val < MODULUS, compared one bit wider so MODULUS == 2**WIDTH works.
    assign w_load_ok      = ({1'b0, load_val} <= {1'b0, c_MAX});
    assign w_load_clamped = w_load_ok ? load_val : c_MAX;

    // Next-state selection: load > count > hold (reset handled in the register).
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        ovf_d  = ovf_q;

        if (load) begin
            q_d = w_load_clamped;
        end else if (en) begin
            if (up_dn) begin
                q_d = w_at_max ? c_UP_TERM : (q_q + c_ONE);
            end else begin
                q_d = w_at_zero ? c_DN_TERM : (q_q - c_ONE);
            end
        end

        wrap_d = w_wrap_evt;
        // A wrap at the same edge as a clear leaves the flag set.
        ovf_d  = w_wrap_evt | (ovf_q & ~ovf_clr);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            q_q    <= c_RESET_VAL;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    assign Q          = q_q;
    assign tc         = w_tc;
    assign wrap       = wrap_q;
    assign ovf_sticky = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_updown_mod.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_updown_mod
// Description : Scoreboard bench for counter_updown_mod (WIDTH=4, MODULUS=10).
//               Driver issues one directed vector per cycle and queues the
//               hand-computed response; a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_updown_mod;

    localparam int WIDTH = 4;

    typedef struct {
        int         id;
        logic       tc;    // expected before the edge
        logic [3:0] q;     // expected after the edge
        logic       wrap;
        logic       ovf;
    } exp_t;

    logic             clock;
    logic             resetn;
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             ovf_clr;
    logic [WIDTH-1:0] Q;
    logic             tc;
    logic             wrap;
    logic             ovf_sticky;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   step_id = 0;

    counter_updown_mod #(
        .WIDTH    (WIDTH),
        .MODULUS  (10),
        .RESET_VAL(0)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .en        (en),
        .up_dn     (up_dn),
        .load      (load),
        .load_val  (load_val),
        .ovf_clr   (ovf_clr),
        .Q         (Q),
        .tc        (tc),
        .wrap      (wrap),
        .ovf_sticky(ovf_sticky)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input int id, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s step%0d: got %0h want %0h", name, id, got, want);
        end
    endtask

    // One vector per cycle: inputs change at the falling edge.
    task automatic step(input logic rn, input logic e, input logic ud, input logic ld,
                        input logic [3:0] lv, input logic clr,
                        input logic x_tc, input logic [3:0] x_q,
                        input logic x_wrap, input logic x_ovf);
        exp_t ex;
        @(negedge clock);
        resetn   = rn;
        en       = e;
        up_dn    = ud;
        load     = ld;
        load_val = lv;
        ovf_clr  = clr;
        ex.id    = step_id;
        ex.tc    = x_tc;
        ex.q     = x_q;
        ex.wrap  = x_wrap;
        ex.ovf   = x_ovf;
        sb.push_back(ex);
        step_id++;
    endtask

    // Monitor: tc checked mid-low-phase, registered outputs just after the edge.
    initial begin
        exp_t e;
        logic tc_s;
        forever begin
            @(negedge clock);
            #3;
            if (sb.size() > 0) begin
                e    = sb.pop_front();
                tc_s = tc;
                @(posedge clock);
                #1;
                chk("tc", e.id, 32'(tc_s), 32'(e.tc));
                chk("Q", e.id, 32'(Q), 32'(e.q));
                chk("wrap", e.id, 32'(wrap), 32'(e.wrap));
                chk("ovf_sticky", e.id, 32'(ovf_sticky), 32'(e.ovf));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        bad++;
        $display("FAIL timeout: got running want finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        resetn = 1'b0; en = 1'b0; up_dn = 1'b0; load = 1'b0;
        load_val = '0; ovf_clr = 1'b0;

        //   rn e  ud ld lv  clr  tc  Q  wrap ovf
        step(0, 0, 0, 0, 0, 0,   0,  0, 0, 0);   // reset
`ifndef COUNTER_UPDOWN_SATURATE_EN
        // Count up 12 cycles: 1..9,0,1,2
        step(1, 1, 1, 0, 0, 0,   0,  1, 0, 0);
        step(1, 1, 1, 0, 0, 0,   0,  2, 0, 0);
        step(1, 1, 1, 0, 0, 0,   0,  3, 0, 0);
        step(1, 1, 1, 0, 0, 0,   0,  4, 0, 0);
        step(1, 1, 1, 0, 0, 0,   0,  5, 0, 0);
        step(1, 1, 1, 0, 0, 0,   0,  6, 0, 0);
        step(1, 1, 1, 0, 0, 0,   0,  7, 0, 0);
        step(1, 1, 1, 0, 0, 0,   0,  8, 0, 0);
        step(1, 1, 1, 0, 0, 0,   0,  9, 0, 0);
        step(1, 1, 1, 0, 0, 0,   1,  0, 1, 1);   // wrap 9 -> 0
        step(1, 1, 1, 0, 0, 0,   0,  1, 0, 1);
        step(1, 1, 1, 0, 0, 0,   0,  2, 0, 1);
        // Reset, then count down 3: 9,8,7
        step(0, 0, 0, 0, 0, 0,   0,  0, 0, 0);
        step(1, 1, 0, 0, 0, 0,   1,  9, 1, 1);   // wrap 0 -> 9
        step(1, 1, 0, 0, 0, 0,   0,  8, 0, 1);
        step(1, 1, 0, 0, 0, 0,   0,  7, 0, 1);
        // Load: clamp, load beats terminal-count step, plain load
        step(1, 1, 1, 1, 13, 0,  0,  9, 0, 1);   // 13 clamps to 9
        step(1, 1, 1, 1, 3, 0,   1,  3, 0, 1);   // tc=1 but load wins, no wrap
        step(1, 0, 0, 1, 5, 0,   0,  5, 0, 1);
        // Wrap and ovf_clr at the same edge: set wins; then clear alone
        step(1, 0, 0, 1, 9, 0,   0,  9, 0, 1);
        step(1, 1, 1, 0, 0, 1,   1,  0, 1, 1);
        step(1, 0, 0, 0, 0, 1,   0,  0, 0, 0);
        step(1, 0, 1, 0, 0, 0,   0,  0, 0, 0);   // hold
        // Build up state, then reset mid-count overriding load/en
        step(1, 1, 0, 0, 0, 0,   1,  9, 1, 1);   // 0 -> 9 sets ovf
        step(1, 0, 0, 1, 5, 0,   0,  5, 0, 1);
        step(1, 1, 1, 0, 0, 0,   0,  6, 0, 1);
        step(0, 1, 1, 1, 3, 0,   0,  0, 0, 0);   // reset wins
        step(1, 1, 1, 0, 0, 0,   0,  1, 0, 0);   // resumes at once
        // Direction flipping each cycle, back-to-back wraps
        step(1, 1, 1, 0, 0, 0,   0,  2, 0, 0);
        step(1, 1, 0, 0, 0, 0,   0,  1, 0, 0);
        step(1, 1, 0, 0, 0, 0,   0,  0, 0, 0);
        step(1, 1, 0, 0, 0, 0,   1,  9, 1, 1);
        step(1, 1, 1, 0, 0, 0,   1,  0, 1, 1);
        step(1, 0, 1, 0, 0, 0,   0,  0, 0, 1);   // wrap drops after one cycle
`else
        // Count up 12 cycles: saturates at 9, last 3 edges blocked
        step(1, 1, 1, 0, 0, 0,   0,  1, 0, 0);
        step(1, 1, 1, 0, 0, 0,   0,  2, 0, 0);
        step(1, 1, 1, 0, 0, 0,   0,  3, 0, 0);
        step(1, 1, 1, 0, 0, 0,   0,  4, 0, 0);
        step(1, 1, 1, 0, 0, 0,   0,  5, 0, 0);
        step(1, 1, 1, 0, 0, 0,   0,  6, 0, 0);
        step(1, 1, 1, 0, 0, 0,   0,  7, 0, 0);
        step(1, 1, 1, 0, 0, 0,   0,  8, 0, 0);
        step(1, 1, 1, 0, 0, 0,   0,  9, 0, 0);
        step(1, 1, 1, 0, 0, 0,   1,  9, 1, 1);
        step(1, 1, 1, 0, 0, 0,   1,  9, 1, 1);
        step(1, 1, 1, 0, 0, 0,   1,  9, 1, 1);
        // Down from 0 is blocked
        step(0, 0, 0, 0, 0, 0,   0,  0, 0, 0);
        step(1, 1, 0, 0, 0, 0,   1,  0, 1, 1);
        step(1, 1, 1, 0, 0, 0,   0,  1, 0, 1);
        step(1, 0, 0, 0, 0, 1,   0,  1, 0, 0);   // clear
        step(1, 1, 1, 1, 13, 0,  0,  9, 0, 0);   // clamp, load no pulse
        step(1, 1, 0, 0, 0, 0,   0,  8, 0, 0);
`endif

        // Let the monitor drain, bounded.
        repeat (3) @(negedge clock);
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
